pci_target_mem: RTL and testbench
=================================

# pci_target_mem

Parametrised PCI-style target memory with burst transfers, active-low byte-lane write merging, programmable initial wait states and registered read data. It replaces the single-word negedge-write memory in the PCI project datapath and sits behind the target control logic: one start pulse opens a burst, then data phases auto-increment the address until the initiator flags the last phase. All storage and control are on the rising edge of one clock.

## Interface
- DATA_W, 32, data width in bits; multiple of 8
- ADDR_W, 4, word address width
- DEPTH, 16, number of words; must equal 2**ADDR_W
- WAIT_STATES, 1, cycles between start and first data phase; 0..15

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse opening a burst; sampled only in IDLE
- wr  in  1  direction latched with start: 1 = write, 0 = read
- start_addr  in  ADDR_W  first word address, latched with start
- data_vld  in  1  initiator has valid data (write) or accepts data (read) this cycle
- last  in  1  current data phase is the final one; meaningful only when a phase completes
- data_in  in  DATA_W  write data
- be_n  in  DATA_W/8  active-low byte enables; be_n[i] = 0 writes byte i
- data_out  out  DATA_W  registered read data for the current address
- trdy  out  1  target ready; a data phase completes when trdy & data_vld
- busy  out  1  burst in progress (WAIT, XFER or TURN)
- cur_addr  out  ADDR_W  address of the current data phase
- err  out  1  one-cycle pulse: start asserted while busy

## Operation
- States: IDLE, WAIT, XFER, TURN.
- IDLE: trdy=0, busy=0. On start: latch wr and start_addr into cur_addr, load wait counter with WAIT_STATES; next state WAIT if WAIT_STATES>0, else XFER.
- WAIT: busy=1, trdy=0; counter decrements each cycle; at 1, go to XFER.
- XFER: busy=1, trdy=1. A phase completes on trdy & data_vld:
  - write: for each lane i with be_n[i]=0, mem[cur_addr] byte i <= data_in byte i; lanes with be_n[i]=1 keep their old contents. All be_n high is a legal no-op phase.
  - read: be_n ignored; the full word is transferred.
  - cur_addr <= (cur_addr+1) mod DEPTH; wraps from DEPTH-1 to 0.
  - if last=1, go to TURN; else stay in XFER.
- If data_vld=0 in XFER: no write, cur_addr and data_out hold.
- TURN: one cycle, busy=1, trdy=0, then IDLE. A start here is treated as start-while-busy.
- start in WAIT, XFER or TURN: ignored, err=1 for the following cycle only. A burst in progress is unaffected.
- Memory contents are not reset and are undefined until written.

## Timing
- Reset values: trdy=0, busy=0, err=0, data_out=0, cur_addr=0, state IDLE. Reset mid-burst aborts immediately. No write occurs on or after the reset edge.
- Latency: start sampled at edge N. busy=1 from N+1. First trdy=1 at N+1+WAIT_STATES.
- Read data: data_out equals mem[cur_addr] in every XFER cycle with trdy=1. It is loaded at the edge entering XFER and at every completing edge with the next address, including across wrap. Zero-wait back-to-back reads yield one word per cycle.
- Writes are visible to a read burst started on the cycle after TURN.
- Burst length is unbounded. Addresses repeat after DEPTH phases.

## Test plan
- Reset: assert rst asynchronously mid-XFER write burst at addr 5 -> outputs immediately at reset values; mem[6] unchanged afterwards.
- Full-word write burst: WAIT_STATES=1, start addr 2, wr=1, words 0x11111111/0x22222222/0x33333333, last on third, be_n=0000 -> trdy first high 2 cycles after start. Then read burst from 2 returns the same three words back-to-back.
- Byte merge: mem[7]=0xAABBCCDD, write 0x11223344 with be_n=1010 -> read of 7 returns 0xAA22CC44. be_n=1111 -> unchanged.
- Wrap and stall: read burst from 14, four phases, data_vld low for 2 cycles after the first phase -> data_out sequence mem[14],mem[15],mem[0],mem[1]. data_out and cur_addr hold during the stall.
- Start while busy: pulse start during WAIT and during TURN -> err high exactly one cycle each time; burst and address sequence unaffected; state returns to IDLE after TURN.
- WAIT_STATES=0: start at edge N -> trdy=1 at N+1 with data_out=mem[start_addr].

Source files
------------

// File: rtl/pci_target_mem.sv
// PCI-style target memory: burst transfers with auto-incrementing address,
// active-low byte-lane write merging, programmable wait states, registered read data.
module pci_target_mem #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 4,
   parameter int DEPTH       = 16,
   parameter int WAIT_STATES = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  wr,
   input  logic [ADDR_W-1:0]     start_addr,
   input  logic                  data_vld,
   input  logic                  last,
   input  logic [DATA_W-1:0]     data_in,
   input  logic [DATA_W/8-1:0]   be_n,
   output logic [DATA_W-1:0]     data_out,
   output logic                  trdy,
   output logic                  busy,
   output logic [ADDR_W-1:0]     cur_addr,
   output logic                  err
);

   localparam int NB = DATA_W / 8;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_XFER,
      S_TURN
   } state_t;

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                wr_q, wr_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   dout_q;
   logic                err_q, err_d;

   logic [DATA_W-1:0]   mem_q [DEPTH];

   logic                phase_done;
   logic                mem_we;
   logic                rd_load;
   logic [ADDR_W-1:0]   rd_addr;
   logic [ADDR_W-1:0]   addr_inc;

   assign phase_done = (state_q == S_XFER) && data_vld;
   assign addr_inc   = addr_q + ADDR_W'(1);
   // Gating with rst keeps a reset that coincides with a clock edge from committing a write.
   assign mem_we     = phase_done && wr_q && !rst;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = (WAIT_STATES == 0) ? S_XFER : S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q <= 4'd1) begin
               state_d = S_XFER;
            end
         end
         S_XFER: begin
            if (data_vld && last) begin
               state_d = S_TURN;
            end
         end
         S_TURN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State-decoded outputs
   always_comb begin
      trdy = 1'b0;
      busy = 1'b0;
      case (state_q)
         S_IDLE: begin
            trdy = 1'b0;
            busy = 1'b0;
         end
         S_WAIT: begin
            trdy = 1'b0;
            busy = 1'b1;
         end
         S_XFER: begin
            trdy = 1'b1;
            busy = 1'b1;
         end
         S_TURN: begin
            trdy = 1'b0;
            busy = 1'b1;
         end
         default: begin
            trdy = 1'b0;
            busy = 1'b0;
         end
      endcase
   end

   // Datapath next-state: burst context, wait counter and read-port addressing
   always_comb begin
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      rd_load = 1'b0;
      rd_addr = addr_q;
      err_d   = start && (state_q != S_IDLE);
      case (state_q)
         S_IDLE: begin
            if (start) begin
               wr_d   = wr;
               addr_d = start_addr;
               cnt_d  = 4'(WAIT_STATES);
               if (WAIT_STATES == 0) begin
                  rd_load = 1'b1;
                  rd_addr = start_addr;
               end
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               rd_load = 1'b1;
               rd_addr = addr_q;
            end
         end
         S_XFER: begin
            if (data_vld) begin
               addr_d  = addr_inc;
               rd_load = 1'b1;
               rd_addr = addr_inc;
            end
         end
         default: begin
            cnt_d = cnt_q;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         wr_q   <= 1'b0;
         addr_q <= '0;
         dout_q <= '0;
         err_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         wr_q   <= wr_d;
         addr_q <= addr_d;
         err_q  <= err_d;
         if (rd_load) begin
            dout_q <= mem_q[rd_addr];
         end
      end
   end

   // Storage is deliberately left out of reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NB; i++) begin
         if (mem_we && !be_n[i]) begin
            mem_q[addr_q][i*8 +: 8] <= data_in[i*8 +: 8];
         end
      end
   end

   assign data_out = dout_q;
   assign cur_addr = addr_q;
   assign err      = err_q;

endmodule

// File: tb/tb_pci_target_mem.sv
// Directed self-checking bench for pci_target_mem: one instance with one wait state,
// a second with zero wait states.
module tb_pci_target_mem;

   logic        clk;
   logic        rst;

   logic        start, wr, data_vld, last;
   logic [3:0]  start_addr;
   logic [31:0] data_in;
   logic [3:0]  be_n;
   logic [31:0] data_out;
   logic        trdy, busy, err;
   logic [3:0]  cur_addr;

   logic        z_start, z_wr, z_vld, z_last;
   logic [3:0]  z_addr;
   logic [31:0] z_din;
   logic [3:0]  z_be;
   logic [31:0] z_dout;
   logic        z_trdy, z_busy, z_err;
   logic [3:0]  z_cur;

   int pass_cnt = 0;
   int fail_cnt = 0;
   int total    = 0;

   pci_target_mem #(.DATA_W(32), .ADDR_W(4), .DEPTH(16), .WAIT_STATES(1)) dut (
      .clk(clk), .rst(rst), .start(start), .wr(wr), .start_addr(start_addr),
      .data_vld(data_vld), .last(last), .data_in(data_in), .be_n(be_n),
      .data_out(data_out), .trdy(trdy), .busy(busy), .cur_addr(cur_addr), .err(err)
   );

   pci_target_mem #(.DATA_W(32), .ADDR_W(4), .DEPTH(16), .WAIT_STATES(0)) dut0 (
      .clk(clk), .rst(rst), .start(z_start), .wr(z_wr), .start_addr(z_addr),
      .data_vld(z_vld), .last(z_last), .data_in(z_din), .be_n(z_be),
      .data_out(z_dout), .trdy(z_trdy), .busy(z_busy), .cur_addr(z_cur), .err(z_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic start_burst(input logic w, input logic [3:0] a);
      start      = 1'b1;
      wr         = w;
      start_addr = a;
      tick();
      start      = 1'b0;
   endtask

   task automatic wait_trdy(input string tag);
      int n = 0;
      while (!trdy && n < 20) begin
         tick();
         n++;
      end
      chk(tag, {31'd0, trdy}, 32'd1);
   endtask

   task automatic write_phase(input logic [31:0] d, input logic [3:0] b, input logic l);
      data_vld = 1'b1;
      data_in  = d;
      be_n     = b;
      last     = l;
      tick();
      data_vld = 1'b0;
      last     = 1'b0;
      be_n     = 4'hF;
   endtask

   task automatic read_step(input logic l);
      data_vld = 1'b1;
      last     = l;
      tick();
      data_vld = 1'b0;
      last     = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      start = 0; wr = 0; start_addr = 0; data_vld = 0; last = 0; data_in = 0; be_n = 4'hF;
      z_start = 0; z_wr = 0; z_addr = 0; z_vld = 0; z_last = 0; z_din = 0; z_be = 4'hF;
      tick();
      tick();
      rst = 1'b0;

      // Reset values
      chk("rst_trdy", {31'd0, trdy}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_dout", data_out, 32'd0);
      chk("rst_addr", {28'd0, cur_addr}, 32'd0);

      // Full-word write burst at 2 with one wait state
      start_burst(1'b1, 4'd2);
      chk("wr_wait_busy", {31'd0, busy}, 32'd1);
      chk("wr_wait_trdy", {31'd0, trdy}, 32'd0);
      tick();
      chk("wr_lat_trdy", {31'd0, trdy}, 32'd1);
      chk("wr_first_addr", {28'd0, cur_addr}, 32'd2);
      write_phase(32'h11111111, 4'h0, 1'b0);
      write_phase(32'h22222222, 4'h0, 1'b0);
      write_phase(32'h33333333, 4'h0, 1'b1);
      chk("wr_turn_busy", {31'd0, busy}, 32'd1);
      chk("wr_turn_trdy", {31'd0, trdy}, 32'd0);
      chk("wr_turn_addr", {28'd0, cur_addr}, 32'd5);
      tick();
      chk("wr_idle_busy", {31'd0, busy}, 32'd0);

      // Read burst back, one word per cycle
      start_burst(1'b0, 4'd2);
      tick();
      chk("rd_trdy", {31'd0, trdy}, 32'd1);
      chk("rd_w0", data_out, 32'h11111111);
      read_step(1'b0);
      chk("rd_w1", data_out, 32'h22222222);
      chk("rd_a1", {28'd0, cur_addr}, 32'd3);
      read_step(1'b0);
      chk("rd_w2", data_out, 32'h33333333);
      read_step(1'b1);
      chk("rd_turn_trdy", {31'd0, trdy}, 32'd0);
      tick();

      // Byte-lane merge at 7
      start_burst(1'b1, 4'd7);
      wait_trdy("bm_wait0");
      write_phase(32'hAABBCCDD, 4'h0, 1'b1);
      tick();
      start_burst(1'b1, 4'd7);
      wait_trdy("bm_wait1");
      write_phase(32'h11223344, 4'b1010, 1'b1);
      tick();
      start_burst(1'b0, 4'd7);
      wait_trdy("bm_wait2");
      chk("bm_merge", data_out, 32'hAA22CC44);
      read_step(1'b1);
      tick();
      start_burst(1'b1, 4'd7);
      wait_trdy("bm_wait3");
      write_phase(32'hFFFFFFFF, 4'b1111, 1'b1);
      tick();
      start_burst(1'b0, 4'd7);
      wait_trdy("bm_wait4");
      chk("bm_noop", data_out, 32'hAA22CC44);
      read_step(1'b1);
      tick();

      // Wrap and stall: fill 14,15,0,1 then read back with a 2-cycle stall
      start_burst(1'b1, 4'd14);
      wait_trdy("wrap_wait0");
      write_phase(32'hE0E0E0E0, 4'h0, 1'b0);
      write_phase(32'hF0F0F0F0, 4'h0, 1'b0);
      write_phase(32'h00C0FFEE, 4'h0, 1'b0);
      write_phase(32'h01010101, 4'h0, 1'b1);
      tick();
      start_burst(1'b0, 4'd14);
      wait_trdy("wrap_wait1");
      chk("wrap_d14", data_out, 32'hE0E0E0E0);
      chk("wrap_a14", {28'd0, cur_addr}, 32'd14);
      read_step(1'b0);
      chk("wrap_d15", data_out, 32'hF0F0F0F0);
      chk("wrap_a15", {28'd0, cur_addr}, 32'd15);
      tick();
      chk("stall1_d", data_out, 32'hF0F0F0F0);
      chk("stall1_a", {28'd0, cur_addr}, 32'd15);
      tick();
      chk("stall2_d", data_out, 32'hF0F0F0F0);
      chk("stall2_a", {28'd0, cur_addr}, 32'd15);
      read_step(1'b0);
      chk("wrap_d0", data_out, 32'h00C0FFEE);
      chk("wrap_a0", {28'd0, cur_addr}, 32'd0);
      read_step(1'b0);
      chk("wrap_d1", data_out, 32'h01010101);
      read_step(1'b1);
      chk("wrap_end_addr", {28'd0, cur_addr}, 32'd2);
      tick();

      // Start while busy: during WAIT and during TURN
      start_burst(1'b0, 4'd2);
      start      = 1'b1;
      wr         = 1'b1;
      start_addr = 4'd9;
      tick();
      start      = 1'b0;
      chk("sb_wait_err", {31'd0, err}, 32'd1);
      chk("sb_wait_trdy", {31'd0, trdy}, 32'd1);
      chk("sb_wait_addr", {28'd0, cur_addr}, 32'd2);
      chk("sb_wait_dout", data_out, 32'h11111111);
      tick();
      chk("sb_err_clear", {31'd0, err}, 32'd0);
      chk("sb_hold_trdy", {31'd0, trdy}, 32'd1);
      read_step(1'b1);
      chk("sb_turn_busy", {31'd0, busy}, 32'd1);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("sb_turn_err", {31'd0, err}, 32'd1);
      chk("sb_turn_idle", {31'd0, busy}, 32'd0);
      tick();
      chk("sb_turn_err_clr", {31'd0, err}, 32'd0);
      chk("sb_still_idle", {31'd0, busy}, 32'd0);

      // Asynchronous reset mid-burst at 5 must not disturb mem[6]
      start_burst(1'b1, 4'd6);
      wait_trdy("ar_wait0");
      write_phase(32'h66666666, 4'h0, 1'b1);
      tick();
      start_burst(1'b1, 4'd5);
      wait_trdy("ar_wait1");
      write_phase(32'h55555555, 4'h0, 1'b0);
      data_vld = 1'b1;
      data_in  = 32'hDEADBEEF;
      be_n     = 4'h0;
      #2;
      rst = 1'b1;
      #1;
      chk("ar_trdy", {31'd0, trdy}, 32'd0);
      chk("ar_busy", {31'd0, busy}, 32'd0);
      chk("ar_addr", {28'd0, cur_addr}, 32'd0);
      chk("ar_dout", data_out, 32'd0);
      chk("ar_err", {31'd0, err}, 32'd0);
      data_vld = 1'b0;
      be_n     = 4'hF;
      tick();
      rst = 1'b0;
      start_burst(1'b0, 4'd6);
      wait_trdy("ar_wait2");
      chk("ar_mem6", data_out, 32'h66666666);
      read_step(1'b1);
      tick();

      // Zero wait states
      z_start = 1'b1; z_wr = 1'b1; z_addr = 4'd3;
      tick();
      z_start = 1'b0;
      chk("ws0_wr_trdy", {31'd0, z_trdy}, 32'd1);
      z_vld = 1'b1; z_din = 32'h0A0B0C0D; z_be = 4'h0; z_last = 1'b0;
      tick();
      z_din = 32'h12345678; z_last = 1'b1;
      tick();
      z_vld = 1'b0; z_last = 1'b0; z_be = 4'hF;
      tick();
      z_start = 1'b1; z_wr = 1'b0; z_addr = 4'd3;
      tick();
      z_start = 1'b0;
      chk("ws0_rd_trdy", {31'd0, z_trdy}, 32'd1);
      chk("ws0_rd_d3", z_dout, 32'h0A0B0C0D);
      z_vld = 1'b1;
      tick();
      chk("ws0_rd_d4", z_dout, 32'h12345678);
      chk("ws0_rd_a4", {28'd0, z_cur}, 32'd4);
      z_last = 1'b1;
      tick();
      z_vld = 1'b0; z_last = 1'b0;
      tick();
      chk("ws0_idle", {31'd0, z_busy}, 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
